// File: rtl/csi2_packet_parser.sv
// CSI-2 packet parser.
// Takes NUM_LANES bytes per beat from the lane merger, decodes the 4-byte
// packet header, checks its ECC, filters on virtual channel, decodes short
// packets into event pulses, and packs long-packet payload into 32-bit words
// while checking the CRC-16 at the end of the packet.
//
// Ports
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   lane_data           : NUM_LANES bytes; packet byte b travels on lane b%NUM_LANES
//   lane_valid          : high while the beat carries HS bytes; low ends the burst
//   virtual_channel,
//   data_type,
//   word_count          : header fields of the current/last accepted packet
//   frame_start, frame_end,
//   line_start, line_end: one-cycle pulses for short packets DT 0x00..0x03
//   generic_short_valid,
//   generic_short_data  : pulse and WC field for generic short packets DT 0x08..0x0F
//   payload_valid,
//   payload_data,
//   payload_byte_enable : packed payload words, first byte in [7:0]
//   ecc_error, crc_error,
//   crc_ok, truncated   : one-cycle status pulses
module csi2_packet_parser #(
    parameter int         NUM_LANES = 2,
    parameter logic [3:0] VC_MASK   = 4'b1111
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [8*NUM_LANES-1:0] lane_data,
    input  logic                   lane_valid,
    output logic [1:0]             virtual_channel,
    output logic [5:0]             data_type,
    output logic [15:0]            word_count,
    output logic                   frame_start,
    output logic                   frame_end,
    output logic                   line_start,
    output logic                   line_end,
    output logic                   generic_short_valid,
    output logic [15:0]            generic_short_data,
    output logic                   payload_valid,
    output logic [31:0]            payload_data,
    output logic [3:0]             payload_byte_enable,
    output logic                   ecc_error,
    output logic                   crc_error,
    output logic                   crc_ok,
    output logic                   truncated
);

    typedef enum logic [2:0] {WAIT_IDLE, IDLE, HEADER, PAYLOAD, CRC, DRAIN} state_t;

    state_t      state_reg, state_next;
    logic [23:0] hdr_reg, hdr_next;          // DI, WC LSB, WC MSB
    logic [1:0]  hdr_cnt_reg, hdr_cnt_next;
    logic [16:0] remain_reg, remain_next;    // payload bytes still expected
    logic [31:0] acc_reg, acc_next;
    logic [1:0]  fill_reg, fill_next;        // bytes already in acc
    logic [15:0] crc_reg, crc_next;
    logic [7:0]  crc_lo_reg, crc_lo_next;    // first (low) received CRC byte
    logic        crc_cnt_reg, crc_cnt_next;

    logic [1:0]  vc_reg, vc_next;
    logic [5:0]  dt_reg, dt_next;
    logic [15:0] wc_reg, wc_next;
    logic [15:0] gsd_reg, gsd_next;
    logic [31:0] pd_reg, pd_next;
    logic [3:0]  be_reg, be_next;
    logic        fs_next, fe_next, ls_next, le_next, gsv_next, pv_next;
    logic        ecc_err_next, crc_err_next, crc_ok_next, trunc_next;
    logic        fs_reg, fe_reg, ls_reg, le_reg, gsv_reg, pv_reg;
    logic        ecc_err_reg, crc_err_reg, crc_ok_reg, trunc_reg;
    logic [7:0]  cur_byte;

    // CSI-2 header Hamming code; each mask selects the data bits of one parity bit.
    function automatic logic [5:0] ecc_calc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = ^(d & 24'hF12CB7);
        p[1] = ^(d & 24'hF2555B);
        p[2] = ^(d & 24'h749A6D);
        p[3] = ^(d & 24'hB8E38E);
        p[4] = ^(d & 24'hDF03F0);
        p[5] = ^(d & 24'hEFFC00);
        return p;
    endfunction

    // x^16+x^12+x^5+1 processed LSB first (reflected polynomial 0x8408).
    function automatic logic [15:0] crc_update(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) c = (c >> 1) ^ 16'h8408;
            else             c = c >> 1;
        end
        return c;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= WAIT_IDLE;
            hdr_reg     <= '0;
            hdr_cnt_reg <= '0;
            remain_reg  <= '0;
            acc_reg     <= '0;
            fill_reg    <= '0;
            crc_reg     <= '0;
            crc_lo_reg  <= '0;
            crc_cnt_reg <= 1'b0;
            vc_reg      <= '0;
            dt_reg      <= '0;
            wc_reg      <= '0;
            gsd_reg     <= '0;
            pd_reg      <= '0;
            be_reg      <= '0;
            fs_reg      <= 1'b0;
            fe_reg      <= 1'b0;
            ls_reg      <= 1'b0;
            le_reg      <= 1'b0;
            gsv_reg     <= 1'b0;
            pv_reg      <= 1'b0;
            ecc_err_reg <= 1'b0;
            crc_err_reg <= 1'b0;
            crc_ok_reg  <= 1'b0;
            trunc_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            hdr_reg     <= hdr_next;
            hdr_cnt_reg <= hdr_cnt_next;
            remain_reg  <= remain_next;
            acc_reg     <= acc_next;
            fill_reg    <= fill_next;
            crc_reg     <= crc_next;
            crc_lo_reg  <= crc_lo_next;
            crc_cnt_reg <= crc_cnt_next;
            vc_reg      <= vc_next;
            dt_reg      <= dt_next;
            wc_reg      <= wc_next;
            gsd_reg     <= gsd_next;
            pd_reg      <= pd_next;
            be_reg      <= be_next;
            fs_reg      <= fs_next;
            fe_reg      <= fe_next;
            ls_reg      <= ls_next;
            le_reg      <= le_next;
            gsv_reg     <= gsv_next;
            pv_reg      <= pv_next;
            ecc_err_reg <= ecc_err_next;
            crc_err_reg <= crc_err_next;
            crc_ok_reg  <= crc_ok_next;
            trunc_reg   <= trunc_next;
        end
    end

    // The beat is walked byte by byte; state_next and the other *_next
    // signals act as the running state so a state change mid-beat (header
    // done, payload done, CRC done) applies to the following lanes.
    always_comb begin
        state_next   = state_reg;
        hdr_next     = hdr_reg;
        hdr_cnt_next = hdr_cnt_reg;
        remain_next  = remain_reg;
        acc_next     = acc_reg;
        fill_next    = fill_reg;
        crc_next     = crc_reg;
        crc_lo_next  = crc_lo_reg;
        crc_cnt_next = crc_cnt_reg;
        vc_next      = vc_reg;
        dt_next      = dt_reg;
        wc_next      = wc_reg;
        gsd_next     = gsd_reg;
        pd_next      = pd_reg;
        be_next      = be_reg;
        fs_next      = 1'b0;
        fe_next      = 1'b0;
        ls_next      = 1'b0;
        le_next      = 1'b0;
        gsv_next     = 1'b0;
        pv_next      = 1'b0;
        ecc_err_next = 1'b0;
        crc_err_next = 1'b0;
        crc_ok_next  = 1'b0;
        trunc_next   = 1'b0;
        cur_byte     = '0;

        if (!lane_valid) begin
            case (state_reg)
                HEADER, PAYLOAD, CRC: begin
                    trunc_next = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end else begin
            if (state_reg == IDLE) begin
                state_next   = HEADER;
                hdr_cnt_next = '0;
            end
            for (int k = 0; k < NUM_LANES; k++) begin
                cur_byte = lane_data[8*k +: 8];
                case (state_next)
                    HEADER: begin
                        if (hdr_cnt_next != 2'd3) begin
                            hdr_next[8*hdr_cnt_next +: 8] = cur_byte;
                            hdr_cnt_next = hdr_cnt_next + 2'd1;
                        end else if (ecc_calc(hdr_next) != cur_byte[5:0] || cur_byte[7:6] != 2'b00) begin
                            ecc_err_next = 1'b1;
                            state_next   = DRAIN;
                        end else if (!VC_MASK[hdr_next[7:6]]) begin
                            state_next = DRAIN;
                        end else begin
                            vc_next = hdr_next[7:6];
                            dt_next = hdr_next[5:0];
                            wc_next = hdr_next[23:8];
                            if (hdr_next[5:4] == 2'b00) begin
                                // short packet; DT 0x04..0x07 are reserved and produce no pulse
                                fs_next  = (hdr_next[5:0] == 6'h00);
                                fe_next  = (hdr_next[5:0] == 6'h01);
                                ls_next  = (hdr_next[5:0] == 6'h02);
                                le_next  = (hdr_next[5:0] == 6'h03);
                                gsv_next = hdr_next[3];
                                if (hdr_next[3]) gsd_next = hdr_next[23:8];
                                state_next = DRAIN;
                            end else begin
                                remain_next  = {1'b0, hdr_next[23:8]};
                                fill_next    = '0;
                                acc_next     = '0;
                                crc_next     = 16'hFFFF;
                                crc_cnt_next = 1'b0;
                                state_next   = (hdr_next[23:8] == 16'h0000) ? CRC : PAYLOAD;
                            end
                        end
                    end
                    PAYLOAD: begin
                        acc_next[8*fill_next +: 8] = cur_byte;
                        crc_next    = crc_update(crc_next, cur_byte);
                        remain_next = remain_next - 17'd1;
                        if (fill_next == 2'd3 || remain_next == 17'd0) begin
                            pv_next = 1'b1;
                            pd_next = acc_next;
                            case (fill_next)
                                2'd0:    be_next = 4'b0001;
                                2'd1:    be_next = 4'b0011;
                                2'd2:    be_next = 4'b0111;
                                default: be_next = 4'b1111;
                            endcase
                            acc_next  = '0;
                            fill_next = '0;
                        end else begin
                            fill_next = fill_next + 2'd1;
                        end
                        if (remain_next == 17'd0) begin
                            crc_cnt_next = 1'b0;
                            state_next   = CRC;
                        end
                    end
                    CRC: begin
                        if (!crc_cnt_next) begin
                            crc_lo_next  = cur_byte;
                            crc_cnt_next = 1'b1;
                        end else begin
                            crc_ok_next  = ({cur_byte, crc_lo_next} == crc_next);
                            crc_err_next = ({cur_byte, crc_lo_next} != crc_next);
                            state_next   = DRAIN;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign virtual_channel     = vc_reg;
    assign data_type           = dt_reg;
    assign word_count          = wc_reg;
    assign frame_start         = fs_reg;
    assign frame_end           = fe_reg;
    assign line_start          = ls_reg;
    assign line_end            = le_reg;
    assign generic_short_valid = gsv_reg;
    assign generic_short_data  = gsd_reg;
    assign payload_valid       = pv_reg;
    assign payload_data        = pd_reg;
    assign payload_byte_enable = be_reg;
    assign ecc_error           = ecc_err_reg;
    assign crc_error           = crc_err_reg;
    assign crc_ok              = crc_ok_reg;
    assign truncated           = trunc_reg;

endmodule

// File: doc/csi2_packet_parser.md
CSI2_PACKET_PARSER -- requirements
Module: csi2_packet_parser

Interface
REQ-001 Parameter NUM_LANES, default 2: bytes per beat; legal values 1, 2, 4.
REQ-002 Parameter VC_MASK, default 4'b1111: bit v set means virtual channel v is accepted.
REQ-003 Port clock, input, 1: sole clock; all logic on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port lane_data, input, 8*NUM_LANES: packet bytes; lane k at bits [8k+7:8k]; packet byte b on lane b%NUM_LANES.
REQ-006 Port lane_valid, input, 1: all lanes carry HS bytes this beat; falling edge means end of burst.
REQ-007 Port virtual_channel, output, 2: VC of current/last accepted packet.
REQ-008 Port data_type, output, 6: data type of current/last accepted packet.
REQ-009 Port word_count, output, 16: word count field of current/last accepted packet.
REQ-010 Port frame_start, frame_end, line_start, line_end, output, 1 each: one-cycle pulses for DT 0x00..0x03.
REQ-011 Port generic_short_valid, output, 1; generic_short_data, output, 16: pulse and WC field for DT 0x08..0x0F.
REQ-012 Port payload_valid, output, 1; payload_data, output, 32; payload_byte_enable, output, 4: packed payload words, byte 0 in [7:0].
REQ-013 Port ecc_error, crc_error, crc_ok, truncated, output, 1 each: one-cycle status pulses.

Function
REQ-014 States: WAIT_IDLE, IDLE, HEADER, PAYLOAD, CRC, DRAIN.
REQ-015 WAIT_IDLE -> IDLE when lane_valid low; IDLE -> HEADER capture on first lane_valid high beat.
REQ-016 Header: 4 bytes (DI, WC LSB, WC MSB, ECC), collected in 4/NUM_LANES beats.
REQ-017 ECC: compute CSI-2 6-bit Hamming over 24 header bits; compare to ECC byte [5:0], with [7:6] required zero; no correction.
REQ-018 ECC mismatch: ecc_error pulse one cycle after final header beat; no other outputs; -> DRAIN.
REQ-019 VC not in VC_MASK with good ECC: silent drop, -> DRAIN.
REQ-020 Short packet (DT 0x00..0x0F): header fields register, decode pulse one cycle after final header beat, -> DRAIN.
REQ-021 Long packet (DT 0x10..0x3F): -> PAYLOAD; WC = 0 goes directly to CRC.
REQ-022 PAYLOAD: bytes accumulate into 32-bit word; payload_valid with byte_enable 4'hF when 4 bytes collected; at most one word per cycle.
REQ-023 Final partial word (WC%4 != 0): emitted with low byte_enable bits set only for valid bytes, e.g. WC%4 = 3 -> 4'b0111.
REQ-024 Payload words output one cycle after beat completing them.
REQ-025 CRC: CRC-16 x^16+x^12+x^5+1, init 16'hFFFF, LSB-first, over payload bytes only; NUM_LANES bytes per cycle.
REQ-026 CRC field: 2 bytes after payload, LSB first, starting on any lane position; may straddle beats.
REQ-027 After CRC bytes: crc_ok or crc_error pulse (exclusive) one cycle later, -> DRAIN; remaining bytes in beat ignored.
REQ-028 DRAIN: ignore bytes; -> IDLE when lane_valid low.
REQ-029 lane_valid low in HEADER, PAYLOAD or CRC: truncated pulse next cycle; partial payload word discarded; no CRC status; -> IDLE.
REQ-030 word_count counter 17 bits; no wrap at WC = 16'hFFFF.
REQ-031 Status and event pulses never overlap for one packet except payload_valid with crc_ok/crc_error.

Reset
REQ-032 reset: state -> WAIT_IDLE; all pulses, payload_valid, payload_data, byte_enable, virtual_channel, data_type, word_count, generic_short_data cleared to 0.
REQ-033 reset mid-packet: packet abandoned; no truncated pulse; bytes ignored until lane_valid seen low.

Verification
REQ-034 NUM_LANES=2, bytes 00 00 00 00 then lane_valid low -> frame_start pulse, virtual_channel 0, no ecc_error.
REQ-035 Same header with ECC byte 0x01 -> ecc_error pulse, no frame_start.
REQ-036 NUM_LANES=4, long packet DT 0x2A, WC 24, payload FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01, CRC F0 00 -> 6 words, first 32'h020000FF, crc_ok; flipped CRC byte -> crc_error.
REQ-037 NUM_LANES=1, WC 5 DT 0x2A, lane_valid dropped after 3 payload bytes -> truncated, no payload_valid; repeat complete -> words enable 4'hF then 4'b0001.
REQ-038 VC_MASK=4'b0001, frame_start on VC 2 -> no outputs; reset asserted mid-payload while lane_valid high -> no outputs until lane_valid low then next packet decodes.
